// File: rtl/tile_stream_loader_if.sv
// Row-write port and FIFO-bank drive bundle for tile_stream_loader.
// slave: the loader itself; master: the row producer / observer.
interface tile_stream_loader_if #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned BITS  = 8
);
  logic            wr_valid;
  logic            wr_ready;
  logic [BITS-1:0] wr_data [DEPTH-1:0];
  logic            start;
  logic [1:0]      ctl;
  logic [BITS-1:0] tile [DEPTH-1:0][DEPTH-1:0];
  logic            busy;
  logic            done;
  logic [1:0]      full;

  modport master (
    output wr_valid, wr_data, start,
    input  wr_ready, ctl, tile, busy, done, full
  );

  modport slave (
    input  wr_valid, wr_data, start,
    output wr_ready, ctl, tile, busy, done, full
  );
endinterface

// File: rtl/tile_stream_loader.sv
// Ping-pong tile buffer feeding a bank of DEPTH skewed transpose FIFOs.
// One bank fills row by row while the other is parallel-loaded into the FIFOs
// and then shifted out for 2*DEPTH-2 cycles.
module tile_stream_loader #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned BITS  = 8
) (
  input logic                 clk,
  input logic                 rst,
  tile_stream_loader_if.slave bus
);

  localparam int unsigned RowW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(2 * DEPTH);
  localparam logic [RowW-1:0] RowLast = RowW'(DEPTH - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(2 * DEPTH - 3);

  localparam logic [1:0] CtlHold  = 2'b00;
  localparam logic [1:0] CtlLoad  = 2'b01;
  localparam logic [1:0] CtlShift = 2'b10;

  typedef enum logic [1:0] {StIdle, StLoad, StShift} state_e;

  state_e          state_q, state_d;
  logic [1:0]      full_q, full_d;
  logic            fb_q;
  logic            sb_q, sb_d;
  logic [RowW-1:0] wrow_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pend_q, pend_d;

  logic [BITS-1:0] bank_q [1:0][DEPTH-1:0][DEPTH-1:0];

  logic       beat, last_beat, pend_eff, load_enter, clr_full;
  logic [1:0] avail;
  logic [1:0] ctl;
  logic       busy, done;

  assign bus.wr_ready = ~full_q[fb_q];
  assign beat         = bus.wr_valid & ~full_q[fb_q];
  assign last_beat    = beat && (wrow_q == RowLast);
  // A start in this cycle counts as already latched so LOAD follows the very next edge.
  assign pend_eff     = pend_q | bus.start;
  // Full flags including a tile completing at this edge, so LOAD can follow immediately.
  assign avail        = full_q | (last_beat ? (2'b01 << fb_q) : 2'b00);

  assign bus.tile = bank_q[sb_q];
  assign bus.ctl  = ctl;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.full = full_q;

  // Stream sequencer: next state, shift counter and FIFO-bank control.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sb_d       = sb_q;
    ctl        = CtlHold;
    busy       = 1'b0;
    done       = 1'b0;
    load_enter = 1'b0;
    clr_full   = 1'b0;
    case (state_q)
      StIdle: begin
        if (pend_eff && avail[sb_q]) begin
          state_d    = StLoad;
          load_enter = 1'b1;
        end
      end
      StLoad: begin
        ctl      = CtlLoad;
        busy     = 1'b1;
        // FIFOs capture the tile on this edge, so the bank is free afterwards.
        clr_full = 1'b1;
        cnt_d    = '0;
        state_d  = StShift;
      end
      StShift: begin
        ctl   = CtlShift;
        busy  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          done = 1'b1;
          sb_d = ~sb_q;
          // Back-to-back: skip IDLE when the other bank is ready and a start is pending.
          if (pend_eff && avail[~sb_q]) begin
            state_d    = StLoad;
            load_enter = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Full flags and start latch next state.
  always_comb begin
    full_d = avail;
    if (clr_full) full_d[sb_q] = 1'b0;
    pend_d = load_enter ? 1'b0 : pend_eff;
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      full_q  <= 2'b00;
      fb_q    <= 1'b0;
      sb_q    <= 1'b0;
      wrow_q  <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      full_q  <= full_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      if (beat) begin
        if (last_beat) begin
          wrow_q <= '0;
          fb_q   <= ~fb_q;
        end else begin
          wrow_q <= wrow_q + 1'b1;
        end
      end
    end
  end

  // Tile storage; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (beat) bank_q[fb_q][wrow_q] <= bus.wr_data;
  end

endmodule
